// File: rtl/inject_sched.sv
// rtl/inject_sched.sv - sequences NUM_SRC injection buffers onto one router inject port
// Optional SCHED_FIXED_PRIO_EN: lowest-index-first arbitration instead of round-robin.
module inject_sched #(
  parameter int NUM_SRC = 4,
  parameter int PKT_LEN = 30,
  parameter int GAP_CYC = 2,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               start,
  input  logic [NUM_SRC-1:0] src_req,
  input  logic               router_ready,
  output logic [NUM_SRC-1:0] enable,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic               done,
  output logic [NUM_SRC-1:0] served
);
  localparam int CNT_W = $clog2(PKT_LEN + 1);
  // GAP_CYC is the whole idle span between packets, the ARB cycle included
  localparam logic [3:0] GAP_LAST = (GAP_CYC >= 2) ? 4'(GAP_CYC - 2) : 4'd0;
  localparam bit SKIP_GAP = (GAP_CYC < 2);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_INJECT, S_GAP, S_FIN} state_t;
  state_t state, state_nxt;

  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] sel;
  logic [NUM_SRC-1:0] cand;
  logic [CNT_W-1:0]   flit_cnt;
  logic [3:0]         gap_cnt;
  logic               pick_vld;
  logic [ID_W-1:0]    pick_id;
  logic               fire;
  logic               pkt_end;
`ifndef SCHED_FIXED_PRIO_EN
  logic [ID_W-1:0]    rr_ptr;
  int                 idx;
`endif

  // sel is the registered one-hot grant; it is non-zero only in INJECT
  assign enable  = sel & {NUM_SRC{router_ready}};
  assign fire    = |enable;
  assign pkt_end = fire && (flit_cnt == CNT_W'(PKT_LEN));
  assign cand    = pend & ~served;

  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
`ifdef SCHED_FIXED_PRIO_EN
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (|(cand & (NUM_SRC'(1) << i))) begin
        pick_vld = 1'b1;
        pick_id  = ID_W'(i);
      end
    end
`else
    idx = 0;
    // walk offsets downward so the candidate nearest rr_ptr is the one that sticks
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (|(cand & (NUM_SRC'(1) << idx))) begin
        pick_vld = 1'b1;
        pick_id  = ID_W'(idx);
      end
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_ARB;
      S_ARB:    state_nxt = pick_vld ? S_INJECT : S_FIN;
      S_INJECT: if (pkt_end) state_nxt = (SKIP_GAP || ((cand & ~sel) == '0)) ? S_ARB : S_GAP;
      S_GAP:    if (gap_cnt == GAP_LAST) state_nxt = S_ARB;
      S_FIN:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      pend     <= '0;
      sel      <= '0;
      served   <= '0;
      grant_id <= '0;
      flit_cnt <= '0;
      gap_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifndef SCHED_FIXED_PRIO_EN
      rr_ptr   <= '0;
`endif
    end else begin
      state <= state_nxt;
      done  <= (state_nxt == S_FIN);
      case (state)
        S_IDLE: begin
          if (start) begin
            pend   <= src_req;
            served <= '0;
            busy   <= 1'b1;
          end
        end
        S_ARB: begin
          if (pick_vld) begin
            grant_id <= pick_id;
            sel      <= NUM_SRC'(1) << pick_id;
            flit_cnt <= '0;
          end else begin
            busy <= 1'b0;
          end
        end
        S_INJECT: begin
          if (pkt_end) begin
            served  <= served | sel;
            sel     <= '0;
            gap_cnt <= '0;
`ifndef SCHED_FIXED_PRIO_EN
            rr_ptr  <= (grant_id == ID_W'(NUM_SRC - 1)) ? '0 : grant_id + 1'b1;
`endif
          end else if (fire) begin
            flit_cnt <= flit_cnt + 1'b1;
          end
        end
        S_GAP:   gap_cnt <= gap_cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inject_sched.sv
// tb/tb_inject_sched.sv - self-checking bench for inject_sched
// Honours SCHED_FIXED_PRIO_EN to pick the expected serving order.
module tb_inject_sched;
  localparam int NUM_SRC  = 4;
  localparam int PKT_LEN  = 30;
  localparam int GAP_CYC  = 2;
  localparam int ID_W     = 2;
  localparam int GAP_IDLE = (GAP_CYC < 2) ? 1 : GAP_CYC;
  localparam int MAXC     = 1024;

  logic               clk = 1'b0;
  logic               RST = 1'b1;
  logic               start = 1'b0;
  logic [NUM_SRC-1:0] src_req = '0;
  logic               router_ready = 1'b0;
  logic [NUM_SRC-1:0] enable;
  logic [ID_W-1:0]    grant_id;
  logic               busy;
  logic               done;
  logic [NUM_SRC-1:0] served;

  inject_sched #(.NUM_SRC(NUM_SRC), .PKT_LEN(PKT_LEN), .GAP_CYC(GAP_CYC), .ID_W(ID_W)) dut (
    .clk(clk), .RST(RST), .start(start), .src_req(src_req), .router_ready(router_ready),
    .enable(enable), .grant_id(grant_id), .busy(busy), .done(done), .served(served)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  bit   rdy_tr [0:MAXC-1];
  logic [3:0] exp_en_tr [0:MAXC-1];
  int   exp_id_tr [0:MAXC-1];
  int   exp_done;
  int   rr_m = 0;

  typedef struct {
    logic [3:0] req;
    int         exp_done;
    logic [3:0] exp_served;
    int         exp_first;
  } vec_t;
  vec_t vt [6];

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Timeline model: cycle 0 carries start, first packet opens at cycle 2, each packet
  // needs PKT_LEN+1 ready cycles, GAP_IDLE idle cycles separate packets, and done
  // follows one cycle after the cycle that trails the last packet.
  task automatic build_model(input logic [3:0] req, output int first);
    logic [3:0] left;
    int cur, cnt, s, n;
    for (int i = 0; i < MAXC; i++) begin
      exp_en_tr[i] = '0;
      exp_id_tr[i] = 0;
    end
    left = req; cur = 2; first = -1; n = 0;
    while (left != 0) begin
      s = -1;
`ifdef SCHED_FIXED_PRIO_EN
      for (int k = NUM_SRC - 1; k >= 0; k--) if (left[k]) s = k;
`else
      for (int k = 0; k < NUM_SRC; k++)
        if (s < 0 && left[(rr_m + k) % NUM_SRC]) s = (rr_m + k) % NUM_SRC;
`endif
      left[s] = 1'b0;
      rr_m = (s + 1) % NUM_SRC;
      if (first < 0) first = s;
      n++;
      cnt = 0;
      while (cnt < PKT_LEN + 1) begin
        if (rdy_tr[cur]) begin
          exp_en_tr[cur] = 4'(1 << s);
          exp_id_tr[cur] = s;
          cnt++;
        end
        cur++;
      end
      if (left != 0) cur += GAP_IDLE;
    end
    exp_done = (n == 0) ? 2 : cur + 1;
  endtask

  task automatic run_round(input logic [3:0] req, input bit glitch,
                           output int got_done, output logic [3:0] got_served, output int got_first);
    int mfirst, gl_t;
    build_model(req, mfirst);
    gl_t = (exp_done > 2) ? $urandom_range(1, exp_done - 1) : 1;
    got_done = -1; got_first = -1;
    @(posedge clk); #1;
    start = 1'b1; src_req = req; router_ready = rdy_tr[0];
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    for (int t = 1; t <= exp_done + 1; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      router_ready = rdy_tr[t];
      if (glitch && t == gl_t) begin
        start = 1'b1;
        src_req = 4'($urandom);
      end
      @(negedge clk);
      chk("enable", int'(enable), int'(exp_en_tr[t]));
      if (exp_en_tr[t] != 0) chk("grant_id", int'(grant_id), exp_id_tr[t]);
      chk("done", int'(done), int'(t == exp_done));
      chk("busy", int'(busy), int'(t < exp_done));
      if (done && got_done < 0) got_done = t;
      if (enable != 0 && got_first < 0) got_first = int'(grant_id);
    end
    start = 1'b0;
    got_served = served;
    chk("served", int'(served), int'(req));
    chk("first_src", got_first, mfirst);
  endtask

  initial begin
    int gd, gf;
    logic [3:0] gs;
    logic [3:0] rq;

    vt[0] = '{4'b1111, 133, 4'b1111, 0};
    vt[1] = '{4'b0101,  67, 4'b0101, 0};
    vt[2] = '{4'b0000,   2, 4'b0000, -1};
    vt[3] = '{4'b0010,  34, 4'b0010, 1};
`ifdef SCHED_FIXED_PRIO_EN
    vt[4] = '{4'b1001,  67, 4'b1001, 0};
    vt[5] = '{4'b1111, 133, 4'b1111, 0};
`else
    vt[4] = '{4'b1001,  67, 4'b1001, 3};
    vt[5] = '{4'b1111, 133, 4'b1111, 1};
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    RST = 1'b0;
    @(negedge clk);
    chk("rst_enable", int'(enable), 0);
    chk("rst_grant_id", int'(grant_id), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_served", int'(served), 0);

    // Async reset in the middle of source 1's packet (flit_cnt 15 at cycle 50)
    @(posedge clk); #1;
    start = 1'b1; src_req = 4'b1111; router_ready = 1'b1;
    for (int t = 1; t <= 50; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    #2;
    chk("pre_rst_grant_id", int'(grant_id), 1);
    chk("pre_rst_enable", int'(enable), 4'b0010);
    RST = 1'b1;
    #1;
    chk("async_rst_enable", int'(enable), 0);
    chk("async_rst_grant_id", int'(grant_id), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_done", int'(done), 0);
    chk("async_rst_served", int'(served), 0);
    @(negedge clk);
    RST = 1'b0;
    rr_m = 0;

    // Table: full-rate rounds, the last one with a start/src_req glitch mid-round
    for (int i = 0; i < MAXC; i++) rdy_tr[i] = 1'b1;
    for (int v = 0; v < 6; v++) begin
      run_round(vt[v].req, v == 5, gd, gs, gf);
      chk("tbl_done_cycle", gd, vt[v].exp_done);
      chk("tbl_served", int'(gs), int'(vt[v].exp_served));
      chk("tbl_first_src", gf, vt[v].exp_first);
    end

    // Five-cycle stall starting when flit_cnt reaches 10
    for (int i = 12; i <= 16; i++) rdy_tr[i] = 1'b0;
    run_round(4'b0001, 1'b0, gd, gs, gf);
    chk("stall_done_cycle", gd, 39);

    // Randomised rounds with random stalls and mid-round glitches
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < MAXC; i++) rdy_tr[i] = (i < 400) ? ($urandom_range(0, 3) != 0) : 1'b1;
      rq = 4'($urandom);
      run_round(rq, 1'b1, gd, gs, gf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
